// File: rtl/rv_pkg.sv
// Shared RV32 execute-stage definitions: operand width, divide opcodes and divider FSM states.
package rv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  // Bit 0 of the opcode selects the unsigned flavour for both DIV/DIVU and REM/REMU.
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] quo_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic [W-1:0] quo_out
);

  logic [W:0] rem_sh;
  logic [W:0] trial;
  logic       ge;

  assign rem_sh = {rem_in, quo_in[W-1]};
  assign trial  = rem_sh - {1'b0, divisor};

  // A set top bit in rem_sh already exceeds any divisor; otherwise trial[W] is the borrow.
  assign ge = rem_sh[W] | ~trial[W];

  assign rem_out = ge ? trial[W-1:0] : rem_sh[W-1:0];
  assign quo_out = {quo_in[W-2:0], ge};

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU; stalls the pipeline via busy_o while in flight.
module div_unit #(
  parameter int XLEN = rv_pkg::XLEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  import rv_pkg::*;

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q;
  div_op_e         op_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic [XLEN-1:0] divisor_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] result_q;

  logic            signed_op;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            b_zero;
  logic            overflow;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] final_res;

  assign signed_op = is_signed_op(op_i);
  assign a_neg     = signed_op & a_i[XLEN-1];
  assign b_neg     = signed_op & b_i[XLEN-1];
  assign a_abs     = a_neg ? -a_i : a_i;
  assign b_abs     = b_neg ? -b_i : b_i;
  assign b_zero    = (b_i == '0);
  assign overflow  = signed_op & (a_i == MIN_NEG) & (b_i == '1);

  // Results that bypass the iteration entirely: divide-by-zero and the signed overflow case.
  always_comb begin
    special_res = '0;
    if (b_zero) begin
      case (div_op_e'(op_i))
        REM, REMU: special_res = a_i;
        default:   special_res = '1;
      endcase
    end else begin
      case (div_op_e'(op_i))
        REM, REMU: special_res = '0;
        default:   special_res = MIN_NEG;
      endcase
    end
  end

  div_step #(.W(XLEN)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (divisor_q),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  assign quo_fix = neg_quo_q ? -quo_nx : quo_nx;
  assign rem_fix = neg_rem_q ? -rem_nx : rem_nx;

  always_comb begin
    case (op_q)
      REM, REMU: final_res = rem_fix;
      default:   final_res = quo_fix;
    endcase
  end

  // busy_o is combinational in IDLE so the issuing instruction is held in its first E cycle.
  always_comb begin
    busy_o = 1'b0;
    case (state_q)
      IDLE:    busy_o = start_i & ~flush_i;
      CALC:    busy_o = ~flush_i;
      default: busy_o = 1'b0;
    endcase
  end

  assign done_o   = (state_q == DONE) & ~flush_i;
  assign result_o = result_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      op_q      <= DIV;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            op_q      <= div_op_e'(op_i);
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            divisor_q <= b_abs;
            quo_q     <= a_abs;
            rem_q     <= '0;
            cnt_q     <= CW'(XLEN);
            if (b_zero || overflow) begin
              result_q <= special_res;
              state_q  <= DONE;
            end else begin
              state_q  <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            result_q <= final_res;
            state_q  <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table through a result scoreboard, plus flush/reset/back-to-back sequences.
module tb_div_unit;

  import rv_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          special;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          done_cycle;
    int          busy_cycles;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  int expected_dones = 0;
  exp_t scoreboard[$];
  vec_t vecs[16];

  div_unit #(.XLEN(32)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .flush_i  (flush),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  always #5 clk = ~clk;

  // Count every done pulse so spurious or doubled completions are caught globally.
  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input int cyc, input int busy_cnt);
    exp_t e;
    if (scoreboard.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_done actual=done required=no_pending_op");
    end else begin
      e = scoreboard.pop_front();
      check({e.tag, "_result"}, result, e.res);
      check({e.tag, "_done_cycle"}, 32'(cyc), 32'(e.done_cycle));
      check({e.tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e.busy_cycles));
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the edge that ends DONE.
  task automatic applyStimulus(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                               input logic [31:0] res_v, input bit special, input bit keep_start,
                               input string tag);
    exp_t e;
    int   busy_cnt;
    bit   got;
    start = 1'b1;
    op    = op_v;
    a     = a_v;
    b     = b_v;
    e.res         = res_v;
    e.done_cycle  = special ? 1 : 33;
    e.busy_cycles = special ? 1 : 33;
    e.tag         = tag;
    scoreboard.push_back(e);
    expected_dones++;
    busy_cnt = 0;
    got      = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        checkOutput(c, busy_cnt);
        got = 1'b1;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=no_done required=done", tag);
      if (scoreboard.size() != 0) void'(scoreboard.pop_back());
    end
    @(posedge clk);
    #1;
    if (!keep_start) start = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{DIVU, 32'd100,        32'd7,          32'd14,         1'b0};
    vecs[1]  = '{REMU, 32'd100,        32'd7,          32'd2,          1'b0};
    vecs[2]  = '{DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
    vecs[3]  = '{REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
    vecs[4]  = '{DIVU, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  1'b1};
    vecs[5]  = '{REMU, 32'h0000_1234,  32'd0,          32'h0000_1234,  1'b1};
    vecs[6]  = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
    vecs[7]  = '{REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  1'b1};
    vecs[8]  = '{DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0};
    vecs[9]  = '{REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0};
    vecs[10] = '{DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0};
    vecs[11] = '{REMU, 32'hFFFF_FFFF,  32'h10,         32'hF,          1'b0};
    vecs[12] = '{DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[13] = '{REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1};
    vecs[14] = '{DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0};
    vecs[15] = '{REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].special, 1'b0,
                    $sformatf("vec%0d", i));
    end

    // Flush in the middle of CALC: no done, busy dropped, last result kept.
    start = 1'b1;
    op    = DIVU;
    a     = 32'd100;
    b     = 32'd7;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("flush_busy_before", {31'd0, busy}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("post_flush_busy", {31'd0, busy}, 32'd0);
    check("result_hold", result, 32'hFFFF_FFFE);
    @(posedge clk);
    #1;
    applyStimulus(DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 1'b0, "after_flush");

    // Back-to-back: start stays high into the cycle after DONE with new operands.
    applyStimulus(DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1, "b2b_first");
    applyStimulus(REMU, 32'd9,   32'd4, 32'd1,  1'b0, 1'b0, "b2b_second");

    // Reset in the middle of CALC abandons the op and clears outputs.
    start = 1'b1;
    op    = DIVU;
    a     = 32'd100;
    b     = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_result", result, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    applyStimulus(DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 1'b0, "after_reset");

    repeat (3) @(posedge clk);
    check("done_count", 32'(done_seen), 32'(expected_dones));
    check("scoreboard_empty", 32'(scoreboard.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU ops, located in the execute stage.
- It is the requesting end of the pipeline stall interface. While a divide is in flight it raises busy_o, and the hazard unit ORs this into stall_f/stall_d and holds the E stage.
- It honours the E-stage flush and abandons work on it.
- It returns one 32-bit result with a single-cycle done pulse.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN; counter width is $clog2(XLEN)+1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- start_i  in  1  a divide op is valid in E. Held high for as long as the instruction stays in E.
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU. Sampled with start_i in IDLE.
- a_i  in  XLEN  dividend (forwarded rs1 value).
- b_i  in  XLEN  divisor (forwarded rs2 value).
- flush_i  in  1  E-stage flush; kills any operation in progress.
- busy_o  out  1  stall request to the hazard unit.
- done_o  out  1  one-cycle pulse; result_o is valid in that cycle.
- result_o  out  XLEN  quotient or remainder, selected by the latched op.

Behaviour:
- Reset (rst_ni=0 at a clock edge): state=IDLE; counter, operand and result registers cleared; busy_o=0, done_o=0, result_o=0. Reset mid-operation abandons the op with no done_o.
- States are IDLE, CALC and DONE.
- IDLE:
  - busy_o = start_i & ~flush_i (combinational, so the issuing instruction is held in E in its first cycle).
  - On start_i & ~flush_i: latch op, sign flags, |a| and |b| (magnitudes only for signed ops); clear the remainder accumulator; set counter=XLEN.
  - Special cases go directly to DONE:
    - b==0: quotient=all ones, remainder=a.
    - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): quotient=0x80000000, remainder=0.
  - Otherwise go to CALC.
- CALC:
  - busy_o=1.
  - Each cycle performs one restoring step: {rem,quo} shifted left 1; trial = rem - divisor; if non-negative, rem=trial and quo LSB=1. Then counter decrements.
  - When counter reaches 1 (the XLEN-th step), apply sign fix-up into result_o and go to DONE:
    - Quotient is negated if the signs differ (signed ops only).
    - Remainder takes the dividend's sign.
- DONE:
  - busy_o=0, done_o=1, result_o valid.
  - The pipeline advances at the end of this cycle.
  - Next state is always IDLE. A following divide is seen as a fresh start_i in IDLE; there is no back-to-back start from DONE.
- Latency:
  - Normal op: busy_o high for XLEN+1 cycles (IDLE cycle plus XLEN CALC cycles); done_o in cycle XLEN+1 counted from 0.
  - Special case: busy_o high for 1 cycle; done_o in cycle 1.
- flush_i in any state: next state=IDLE, no done_o. busy_o is forced 0 in that cycle.
  - flush_i in DONE suppresses done_o in that cycle.
- start_i deasserting in CALC without flush_i: illegal per protocol. The unit completes and pulses done_o regardless.
- result_o holds its value after DONE until the next completion.
- All arithmetic is unsigned on XLEN+1-bit trial subtraction; negation is two's complement modulo 2^XLEN.

Decomposition:
- Shared package rv_pkg holds:
  - div_op_e enum (DIV, DIVU, REM, REMU, 2 bits), also used by the decoder.
  - div_state_e enum (IDLE, CALC, DONE).
  - XLEN constant.
- One natural sub-module, div_step: a combinational single restoring iteration (rem_in, quo_in, divisor -> rem_out, quo_out). It keeps the FSM file small and allows later unrolling.

Test Plan:
- DIVU a=100, b=7 -> busy_o high 33 cycles, done_o in cycle 33, result_o=14. Repeat with REMU -> result_o=2.
- DIV a=0xFFFFFFF9 (-7), b=2 -> result_o=0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1).
- DIVU a=0x1234, b=0 -> busy_o 1 cycle, done_o cycle 1, result_o=0xFFFFFFFF. REMU a=0x1234, b=0 -> result_o=0x1234.
- DIV a=0x80000000, b=0xFFFFFFFF -> result_o=0x80000000 after 1 busy cycle. REM same operands -> result_o=0.
- Start DIVU 100/7, assert flush_i at CALC cycle 10 -> busy_o=0 that cycle, state IDLE next, no done_o. A new DIVU 9/3 then completes with result_o=3.
- Two back-to-back divides, with start_i re-asserted in the cycle after DONE -> second op enters CALC with no lost cycle and no double done_o. Also pull rst_ni low mid-CALC -> all outputs 0 at the next edge.
